// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths and grant encoding for the register writeback arbiter.
package reg_wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;
endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; Last_Grant advances only when a grant is issued.
module rr_arb2
    import reg_wb_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic Hold,
    input  logic Req_Alu,
    input  logic Req_Mem,
    output logic Gnt_Alu,
    output logic Gnt_Mem
);
    gnt_t last_grant, next_grant;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) last_grant <= GNT_MEM;
        else       last_grant <= next_grant;
    end

    // Grants are issued only to a valid requester, so a grant is a transfer.
    always_comb begin
        Gnt_Alu    = !Reset && !Hold && Req_Alu && (!Req_Mem || last_grant == GNT_MEM);
        Gnt_Mem    = !Reset && !Hold && Req_Mem && (!Req_Alu || last_grant == GNT_ALU);
        next_grant = Gnt_Alu ? GNT_ALU : Gnt_Mem ? GNT_MEM : last_grant;
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges ALU and load writebacks into one registered register-file write port.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Hold,
    input  logic              Alu_Valid,
    input  logic [ADDR_W-1:0] Alu_Reg,
    input  logic [DATA_W-1:0] Alu_Data,
    output logic              Alu_Ready,
    input  logic              Mem_Valid,
    input  logic [ADDR_W-1:0] Mem_Reg,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic              Mem_Ready,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] Write_Register,
    output logic [DATA_W-1:0] Write_Data,
    output logic [CNT_W-1:0]  Commit_Count
);
    logic              gnt_alu, gnt_mem, commit;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .Clock   (Clock),
        .Reset   (Reset),
        .Hold    (Hold),
        .Req_Alu (Alu_Valid),
        .Req_Mem (Mem_Valid),
        .Gnt_Alu (gnt_alu),
        .Gnt_Mem (gnt_mem)
    );

    assign Alu_Ready = gnt_alu;
    assign Mem_Ready = gnt_mem;

    // Index-0 transfers are accepted but dropped here, like writes to a hardwired zero register.
    always_comb begin
        sel_reg  = gnt_alu ? Alu_Reg : Mem_Reg;
        sel_data = gnt_alu ? Alu_Data : Mem_Data;
        commit   = (gnt_alu || gnt_mem) && sel_reg != '0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Reg_Write      <= 1'b0;
            Write_Register <= '0;
            Write_Data     <= '0;
            Commit_Count   <= '0;
        end else begin
            Reg_Write <= commit;
            if (commit) begin
                Write_Register <= sel_reg;
                Write_Data     <= sel_data;
                if (Commit_Count != '1) Commit_Count <= Commit_Count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed checks of grant, latency, index-0, hold, reset and saturation.
module tb_reg_wb_arbiter;
    logic        Clock = 1'b0, Reset, Hold;
    logic        Alu_Valid, Mem_Valid, Alu_Ready, Mem_Ready, Reg_Write;
    logic [4:0]  Alu_Reg, Mem_Reg, Write_Register;
    logic [31:0] Alu_Data, Mem_Data, Write_Data;
    logic [3:0]  Commit_Count;
    int total = 0, bad = 0;

    reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .Hold(Hold),
        .Alu_Valid(Alu_Valid), .Alu_Reg(Alu_Reg), .Alu_Data(Alu_Data), .Alu_Ready(Alu_Ready),
        .Mem_Valid(Mem_Valid), .Mem_Reg(Mem_Reg), .Mem_Data(Mem_Data), .Mem_Ready(Mem_Ready),
        .Reg_Write(Reg_Write), .Write_Register(Write_Register), .Write_Data(Write_Data),
        .Commit_Count(Commit_Count)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic rw, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [3:0] cnt);
        chk({tag, "_rw"}, 32'(Reg_Write), 32'(rw));
        chk({tag, "_wr"}, 32'(Write_Register), 32'(wr));
        chk({tag, "_wd"}, Write_Data, wd);
        chk({tag, "_cnt"}, 32'(Commit_Count), 32'(cnt));
    endtask

    task automatic rdy(input string tag, input logic a, input logic m);
        chk({tag, "_alu_rdy"}, 32'(Alu_Ready), 32'(a));
        chk({tag, "_mem_rdy"}, 32'(Mem_Ready), 32'(m));
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Hold = 1'b0;
        Alu_Valid = 1'b1; Alu_Reg = 5'd6; Alu_Data = 32'h66;
        Mem_Valid = 1'b1; Mem_Reg = 5'd7; Mem_Data = 32'h77;
        #1;
        rdy("reset", 1'b0, 1'b0);
        outs("reset", 1'b0, 5'd0, 32'h0, 4'd0);
        tick;
        outs("reset_edge", 1'b0, 5'd0, 32'h0, 4'd0);
        Alu_Valid = 1'b0; Mem_Valid = 1'b0; Reset = 1'b0;
        tick;
        outs("idle", 1'b0, 5'd0, 32'h0, 4'd0);
        // single ALU request
        Alu_Valid = 1'b1; Alu_Reg = 5'd5; Alu_Data = 32'h0000_00AA;
        #1 rdy("alu_only", 1'b1, 1'b0);
        tick;
        outs("alu_only", 1'b1, 5'd5, 32'hAA, 4'd1);
        Alu_Valid = 1'b0;
        #1 rdy("none", 1'b0, 1'b0);
        tick;
        outs("hold_vals", 1'b0, 5'd5, 32'hAA, 4'd1);
        // round-robin after reset: ALU first, then MEM, then ALU again
        Reset = 1'b1; #1; Reset = 1'b0;
        Alu_Valid = 1'b1; Alu_Reg = 5'd3; Alu_Data = 32'h11;
        Mem_Valid = 1'b1; Mem_Reg = 5'd4; Mem_Data = 32'h22;
        #1 rdy("rr1", 1'b1, 1'b0);
        tick;
        outs("rr1", 1'b1, 5'd3, 32'h11, 4'd1);
        rdy("rr2", 1'b0, 1'b1);
        tick;
        outs("rr2", 1'b1, 5'd4, 32'h22, 4'd2);
        Mem_Reg = 5'd8; Mem_Data = 32'h88;
        #1 rdy("rr3", 1'b1, 1'b0);
        tick;
        outs("rr3", 1'b1, 5'd3, 32'h11, 4'd3);
        Alu_Valid = 1'b0;
        #1 rdy("mem_only", 1'b0, 1'b1);
        tick;
        outs("mem_only", 1'b1, 5'd8, 32'h88, 4'd4);
        // index-0 transfer accepted but not written
        Mem_Reg = 5'd0; Mem_Data = 32'hFFFF_FFFF;
        #1 rdy("zero_idx", 1'b0, 1'b1);
        tick;
        outs("zero_idx", 1'b0, 5'd8, 32'h88, 4'd4);
        Mem_Valid = 1'b0;
        // hold stalls grants
        Hold = 1'b1; Alu_Valid = 1'b1; Alu_Reg = 5'd7; Alu_Data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1 rdy("hold", 1'b0, 1'b0);
            tick;
            outs("hold", 1'b0, 5'd8, 32'h88, 4'd4);
        end
        Hold = 1'b0;
        #1 rdy("unhold", 1'b1, 1'b0);
        tick;
        outs("unhold", 1'b1, 5'd7, 32'h77, 4'd5);
        // async reset mid-cycle discards in-flight request
        Alu_Reg = 5'd9; Alu_Data = 32'h99;
        #2 Reset = 1'b1;
        #1;
        outs("async_rst", 1'b0, 5'd0, 32'h0, 4'd0);
        rdy("async_rst", 1'b0, 1'b0);
        tick;
        Reset = 1'b0; Alu_Valid = 1'b0;
        tick;
        outs("post_rst", 1'b0, 5'd0, 32'h0, 4'd0);
        // saturation with a 4-bit counter
        Alu_Valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            Alu_Reg = 5'(i % 31 + 1); Alu_Data = 32'(i + 100);
            tick;
            outs("sat", 1'b1, 5'(i % 31 + 1), 32'(i + 100), (i < 15) ? 4'(i + 1) : 4'd15);
        end
        Alu_Valid = 1'b0;
        tick;
        outs("sat_end", 1'b0, 5'd17, 32'd116, 4'd15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, register data width; ADDR_W, default 5, register index width; CNT_W, default 16, commit counter width.
REQ-002 Clock  input  1  single rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Hold  input  1  pipeline stall; while high, no grants are issued.
REQ-005 Alu_Valid  input  1  ALU writeback request.
REQ-006 Alu_Reg  input  ADDR_W  ALU destination register.
REQ-007 Alu_Data  input  DATA_W  ALU result.
REQ-008 Alu_Ready  output  1  ALU request accepted this cycle.
REQ-009 Mem_Valid  input  1  load-unit writeback request.
REQ-010 Mem_Reg  input  ADDR_W  load destination register.
REQ-011 Mem_Data  input  DATA_W  load data.
REQ-012 Mem_Ready  output  1  load request accepted this cycle.
REQ-013 Reg_Write  output  1  register-file write enable, registered.
REQ-014 Write_Register  output  ADDR_W  register-file write index, registered.
REQ-015 Write_Data  output  DATA_W  register-file write data, registered.
REQ-016 Commit_Count  output  CNT_W  count of committed nonzero-index writes.

Function
REQ-017 Handshake SHALL be valid/ready: a transfer occurs when Valid and Ready are both high at a rising edge; the requester holds Valid, Reg and Data stable until then.
REQ-018 Ready outputs SHALL be combinational from Valid, Hold and Last_Grant; at most one Ready SHALL be high per cycle.
REQ-019 With Hold=1, both Ready outputs SHALL be 0 and Reg_Write SHALL be 0 in the following cycle.
REQ-020 With only one Valid high and Hold=0, that requester SHALL be granted.
REQ-021 With both Valid high and Hold=0, the requester not granted most recently SHALL be granted (round-robin); Last_Grant SHALL update only on a transfer.
REQ-022 Latency SHALL be one cycle: the transferred request appears on Write_Register/Write_Data with Reg_Write=1 for exactly the cycle after the transfer edge.
REQ-023 A transfer with index 0 SHALL be accepted (Ready=1) but SHALL produce Reg_Write=0 and SHALL NOT increment Commit_Count.
REQ-024 Without a transfer, Reg_Write SHALL be 0 next cycle; Write_Register and Write_Data SHALL hold their last values.
REQ-025 Commit_Count SHALL increment by 1 per committed nonzero-index write and SHALL saturate at all-ones.
REQ-026 Throughput SHALL be one transfer per cycle; a requester held valid while the other is also valid SHALL be granted within 2 cycles.

Reset
REQ-027 Reset assertion SHALL immediately force Reg_Write=0, Write_Register=0, Write_Data=0, Commit_Count=0, Last_Grant=MEM (so ALU wins the first conflict).
REQ-028 While Reset is high, both Ready outputs SHALL be 0; a request in flight at reset assertion SHALL be discarded and never written.
REQ-029 Reset deassertion SHALL allow the first grant at the next rising edge.

Structure
REQ-030 A shared package reg_wb_pkg SHALL hold DATA_W/ADDR_W/CNT_W defaults and the grant encoding (GNT_ALU, GNT_MEM).
REQ-031 One sub-module, rr_arb2 (two-input round-robin grant with Last_Grant state), is natural; the output register and counter reside in the top.

Verification
REQ-032 Alu_Valid=1, Alu_Reg=5, Alu_Data=0x0000_00AA, Mem_Valid=0 -> Alu_Ready=1 same cycle; next cycle Reg_Write=1, Write_Register=5, Write_Data=0xAA; Commit_Count=1.
REQ-033 After reset, both valid (ALU r3=0x11, MEM r4=0x22) held -> cycle 1 ALU granted, cycle 2 MEM granted; outputs r3/0x11 then r4/0x22 on consecutive cycles.
REQ-034 Mem_Valid=1, Mem_Reg=0, Mem_Data=0xFFFF_FFFF -> Mem_Ready=1; next cycle Reg_Write=0; Commit_Count unchanged.
REQ-035 Hold=1 for 3 cycles with Alu_Valid=1 -> Alu_Ready=0 and Reg_Write=0 throughout; first cycle after Hold=0 -> Alu_Ready=1.
REQ-036 Reset asserted mid-cycle after a transfer edge -> Reg_Write drops to 0 asynchronously, Commit_Count=0, no write emitted after deassertion.
REQ-037 CNT_W=4, 17 nonzero-index commits -> Commit_Count stops at 15.
